// File: rtl/key_load_shifter.sv
// Bit-serial key loader: receives a checksummed key frame, verifies it, and
// holds the verified key for the locked netlist. A decoy key is driven until then.
module key_load_shifter #(
    parameter int               KEY_W     = 16,
    parameter logic [KEY_W-1:0] DECOY_KEY = {KEY_W{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       key_start,
    input  logic                       key_bit,
    input  logic                       key_bit_valid,
    output logic                       key_bit_ready,
    output logic [KEY_W-1:0]           key_out,
    output logic                       key_locked,
    output logic                       key_error,
    output logic [$clog2(KEY_W+4):0]   bit_count
);

    localparam int FRAME_W = KEY_W + 4;
    localparam int CNT_W   = $clog2(KEY_W + 4) + 1;
    localparam int NIBBLES = KEY_W / 4;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        LOCKED,
        ERROR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [FRAME_W-1:0] shift_reg;
    logic               accept;
    logic               clear;
    logic               last_bit;
    logic               sum_ok;

    function automatic logic [3:0] nibble_xor(input logic [KEY_W-1:0] k);
        logic [3:0] acc;
        acc = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            acc = acc ^ k[4*i +: 4];
        end
        return acc;
    endfunction

    // A start in SHIFT wins over a simultaneous bit, so the aborted frame
    // never absorbs the pulse-cycle bit.
    assign accept   = (state == SHIFT) && key_bit_valid && !key_start;
    assign clear    = key_start && ((state == IDLE) || (state == SHIFT) || (state == ERROR));
    assign last_bit = accept && (bit_count == CNT_W'(FRAME_W - 1));
    assign sum_ok   = (nibble_xor(shift_reg[KEY_W-1:0]) == shift_reg[FRAME_W-1:KEY_W]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (key_start) state_nxt = SHIFT;
            SHIFT:   if (last_bit)  state_nxt = CHECK;
            CHECK:   state_nxt = sum_ok ? LOCKED : ERROR;
            LOCKED:  state_nxt = LOCKED;
            ERROR:   if (key_start) state_nxt = SHIFT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            key_bit_ready <= 1'b0;
            bit_count     <= '0;
            key_out       <= DECOY_KEY;
            key_locked    <= 1'b0;
            key_error     <= 1'b0;
        end else begin
            state         <= state_nxt;
            key_bit_ready <= (state_nxt == SHIFT);
            if (clear) begin
                bit_count <= '0;
            end else if (accept) begin
                bit_count <= bit_count + CNT_W'(1);
            end
            if (state == CHECK) begin
                if (sum_ok) begin
                    key_out    <= shift_reg[KEY_W-1:0];
                    key_locked <= 1'b1;
                end else begin
                    key_error  <= 1'b1;
                end
            end else if ((state == ERROR) && key_start) begin
                key_error <= 1'b0;
            end
        end
    end

    // Frame data path; only observable through key_out after verification.
    always_ff @(posedge clk) begin
        if (clear) begin
            shift_reg <= '0;
        end else if (accept) begin
            for (int i = 0; i < FRAME_W; i++) begin
                if (bit_count == CNT_W'(i)) shift_reg[i] <= key_bit;
            end
        end
    end

endmodule

// File: tb/tb_key_load_shifter.sv
// Scoreboard bench for key_load_shifter: frame results are queued when a
// frame is driven and compared when the DUT resolves it.
module tb_key_load_shifter;

    logic        clk;
    logic        rst_n;
    logic        key_start;
    logic        key_bit;
    logic        key_bit_valid;
    logic        key_bit_ready;
    logic [15:0] key_out;
    logic        key_locked;
    logic        key_error;
    logic [5:0]  bit_count;

    typedef struct packed {
        logic        locked;
        logic        error;
        logic [15:0] key;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp;
    int   n_fail;

    key_load_shifter #(.KEY_W(16), .DECOY_KEY(16'h0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_start     (key_start),
        .key_bit       (key_bit),
        .key_bit_valid (key_bit_valid),
        .key_bit_ready (key_bit_ready),
        .key_out       (key_out),
        .key_locked    (key_locked),
        .key_error     (key_error),
        .bit_count     (bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] model_csum(input logic [15:0] k);
        return k[3:0] ^ k[7:4] ^ k[11:8] ^ k[15:12];
    endfunction

    function automatic exp_t model_result(input logic [15:0] k, input logic [3:0] c);
        exp_t r;
        r.locked = (c == model_csum(k));
        r.error  = !r.locked;
        r.key    = r.locked ? k : 16'h0000;
        return r;
    endfunction

    task automatic do_reset();
        key_start     = 1'b0;
        key_bit       = 1'b0;
        key_bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    // Drives one frame (optionally preceded by a start pulse) and queues its result.
    task automatic send_frame(input logic [15:0] k, input logic [3:0] c, input bit do_start);
        logic [19:0] fr;
        fr = {c, k};
        exp_q.push_back(model_result(k, c));
        if (do_start) begin
            key_start     = 1'b1;
            key_bit_valid = 1'b0;
            tick();
            key_start = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            key_bit       = fr[i];
            key_bit_valid = 1'b1;
            tick();
        end
        key_bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        do_reset();
        n_cmp++; if (key_out !== 16'h0000) begin n_fail++; $display("FAIL reset_key_out got=%h exp=%h", key_out, 16'h0000); end
        n_cmp++; if (key_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%b exp=0", key_locked); end
        n_cmp++; if (key_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", key_error); end
        n_cmp++; if (key_bit_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", key_bit_ready); end
        n_cmp++; if (bit_count !== 6'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bit_count); end
    endtask

    task automatic test_good_load();
        logic [19:0] fr;
        int          early_bad;
        fr = {4'h4, 16'h1234};
        early_bad = 0;
        exp_q.push_back(model_result(16'h1234, 4'h4));
        key_start = 1'b1;
        tick();                                   // edge 1
        key_start = 1'b0;
        n_cmp++; if (key_bit_ready !== 1'b1) begin n_fail++; $display("FAIL good_ready_after_start got=%b exp=1", key_bit_ready); end
        for (int i = 0; i < 20; i++) begin
            key_bit       = fr[i];
            key_bit_valid = 1'b1;
            tick();                               // edges 2..21
            if (key_out !== 16'h0000 || key_locked !== 1'b0) early_bad++;
        end
        key_bit_valid = 1'b0;
        n_cmp++; if (early_bad !== 0) begin n_fail++; $display("FAIL good_early_visible got=%0d exp=0", early_bad); end
        n_cmp++; if (bit_count !== 6'd20) begin n_fail++; $display("FAIL good_count got=%0d exp=20", bit_count); end
        n_cmp++; if (key_bit_ready !== 1'b0) begin n_fail++; $display("FAIL good_check_ready got=%b exp=0", key_bit_ready); end
        tick();                                   // edge 22
        e = exp_q.pop_front();
        n_cmp++; if (key_out !== e.key) begin n_fail++; $display("FAIL good_key got=%h exp=%h", key_out, e.key); end
        n_cmp++; if (key_locked !== e.locked) begin n_fail++; $display("FAIL good_locked got=%b exp=%b", key_locked, e.locked); end
        n_cmp++; if (key_error !== e.error) begin n_fail++; $display("FAIL good_error got=%b exp=%b", key_error, e.error); end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        send_frame(16'h1234, 4'h5, 1'b1);
        tick();
        e = exp_q.pop_front();
        n_cmp++; if (key_error !== e.error) begin n_fail++; $display("FAIL bad_error got=%b exp=%b", key_error, e.error); end
        n_cmp++; if (key_locked !== e.locked) begin n_fail++; $display("FAIL bad_locked got=%b exp=%b", key_locked, e.locked); end
        n_cmp++; if (key_out !== e.key) begin n_fail++; $display("FAIL bad_key got=%h exp=%h", key_out, e.key); end
        n_cmp++; if (key_bit_ready !== 1'b0) begin n_fail++; $display("FAIL bad_ready got=%b exp=0", key_bit_ready); end
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        n_cmp++; if (key_error !== 1'b0) begin n_fail++; $display("FAIL retry_error_clear got=%b exp=0", key_error); end
        n_cmp++; if (bit_count !== 6'd0) begin n_fail++; $display("FAIL retry_count got=%0d exp=0", bit_count); end
        send_frame(16'hA5C3, 4'h0, 1'b0);
        tick();
        e = exp_q.pop_front();
        n_cmp++; if (key_out !== e.key) begin n_fail++; $display("FAIL retry_key got=%h exp=%h", key_out, e.key); end
        n_cmp++; if (key_error !== e.error) begin n_fail++; $display("FAIL retry_error got=%b exp=%b", key_error, e.error); end
        n_cmp++; if (key_locked !== e.locked) begin n_fail++; $display("FAIL retry_locked got=%b exp=%b", key_locked, e.locked); end
    endtask

    task automatic test_abort();
        do_reset();
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            key_bit       = 1'b1;
            key_bit_valid = 1'b1;
            tick();
        end
        n_cmp++; if (bit_count !== 6'd7) begin n_fail++; $display("FAIL abort_pre_count got=%0d exp=7", bit_count); end
        key_start = 1'b1;
        key_bit   = 1'b1;
        tick();
        key_start     = 1'b0;
        key_bit_valid = 1'b0;
        n_cmp++; if (bit_count !== 6'd0) begin n_fail++; $display("FAIL abort_count got=%0d exp=0", bit_count); end
        n_cmp++; if (key_bit_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got=%b exp=1", key_bit_ready); end
        send_frame(16'h00F0, 4'hF, 1'b0);
        tick();
        e = exp_q.pop_front();
        n_cmp++; if (key_out !== e.key) begin n_fail++; $display("FAIL abort_key got=%h exp=%h", key_out, e.key); end
        n_cmp++; if (key_locked !== e.locked) begin n_fail++; $display("FAIL abort_locked got=%b exp=%b", key_locked, e.locked); end
    endtask

    task automatic test_gaps();
        logic [19:0] fr;
        int          cnt_bad;
        fr = {4'h4, 16'h1234};
        cnt_bad = 0;
        do_reset();
        exp_q.push_back(model_result(16'h1234, 4'h4));
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            key_bit       = fr[i];
            key_bit_valid = 1'b1;
            tick();
            if (bit_count !== 6'(i + 1)) cnt_bad++;
            key_bit       = ~fr[i];
            key_bit_valid = 1'b0;
            tick();
            if (bit_count !== 6'(i + 1)) cnt_bad++;
        end
        n_cmp++; if (cnt_bad !== 0) begin n_fail++; $display("FAIL gap_count_steps got=%0d exp=0", cnt_bad); end
        e = exp_q.pop_front();
        n_cmp++; if (key_out !== e.key) begin n_fail++; $display("FAIL gap_key got=%h exp=%h", key_out, e.key); end
        n_cmp++; if (key_locked !== e.locked) begin n_fail++; $display("FAIL gap_locked got=%b exp=%b", key_locked, e.locked); end
    endtask

    task automatic test_lock_persist();
        int bad;
        bad = 0;
        key_start     = 1'b1;
        key_bit_valid = 1'b1;
        key_bit       = 1'b1;
        tick();
        key_start = 1'b0;
        if (key_bit_ready !== 1'b0 || key_out !== 16'h1234) bad++;
        for (int i = 0; i < 20; i++) begin
            key_bit = 1'b1;
            tick();
            if (key_bit_ready !== 1'b0 || key_out !== 16'h1234) bad++;
        end
        key_bit_valid = 1'b0;
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL persist_cycles got=%0d exp=0", bad); end
        n_cmp++; if (key_out !== 16'h1234) begin n_fail++; $display("FAIL persist_key got=%h exp=%h", key_out, 16'h1234); end
        n_cmp++; if (key_locked !== 1'b1) begin n_fail++; $display("FAIL persist_locked got=%b exp=1", key_locked); end
        n_cmp++; if (bit_count !== 6'd20) begin n_fail++; $display("FAIL persist_count got=%0d exp=20", bit_count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            key_bit       = 1'b1;
            key_bit_valid = 1'b1;
            tick();
        end
        key_bit_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (bit_count !== 6'd0) begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", bit_count); end
        n_cmp++; if (key_bit_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got=%b exp=0", key_bit_ready); end
        tick();
        #2 rst_n = 1'b1;
        tick();
        send_frame(16'h1234, 4'h4, 1'b1);
        tick();
        e = exp_q.pop_front();
        n_cmp++; if (key_out !== e.key) begin n_fail++; $display("FAIL prerst_key got=%h exp=%h", key_out, e.key); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (key_out !== 16'h0000) begin n_fail++; $display("FAIL lockrst_key got=%h exp=%h", key_out, 16'h0000); end
        n_cmp++; if (key_locked !== 1'b0) begin n_fail++; $display("FAIL lockrst_locked got=%b exp=0", key_locked); end
        n_cmp++; if (key_error !== 1'b0) begin n_fail++; $display("FAIL lockrst_error got=%b exp=0", key_error); end
        tick();
        #2 rst_n = 1'b1;
        key_bit       = 1'b1;
        key_bit_valid = 1'b1;
        tick();
        tick();
        tick();
        key_bit_valid = 1'b0;
        n_cmp++; if (bit_count !== 6'd0) begin n_fail++; $display("FAIL nostart_count got=%0d exp=0", bit_count); end
        n_cmp++; if (key_bit_ready !== 1'b0) begin n_fail++; $display("FAIL nostart_ready got=%b exp=0", key_bit_ready); end
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        rst_n         = 1'b1;
        key_start     = 1'b0;
        key_bit       = 1'b0;
        key_bit_valid = 1'b0;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_abort();
        test_gaps();
        test_lock_persist();
        test_async_reset();
        n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/key_load_shifter.md
# key_load_shifter

Serial key-load stage that sits directly upstream of the RLL-locked combinational netlists. It accepts the secret key as a checksummed bit-serial frame, verifies it, and holds it in a locked register whose bits drive the netlist key inputs (`key_out[i]` → `keyIn_0_i`). A decoy key is presented until a frame verifies, and once committed the key cannot be reloaded without reset.

## Interface
Parameters
- `KEY_W`, 16: key width; must be a multiple of 4.
- `DECOY_KEY`, `{KEY_W{1'b0}}`: value driven on `key_out` whenever no verified key is held.

Ports
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `key_start`  in  1  single-cycle pulse that begins or restarts a frame.
- `key_bit`  in  1  serial data bit.
- `key_bit_valid`  in  1  `key_bit` is valid this cycle.
- `key_bit_ready`  out  1  block accepts a bit this cycle.
- `key_out`  out  `KEY_W`  key to the locked netlist; bit i drives `keyIn_0_i`.
- `key_locked`  out  1  a verified key is held and driven.
- `key_error`  out  1  the last frame failed its checksum.
- `bit_count`  out  `$clog2(KEY_W+4)+1`  accepted bits in the current frame.

## Operation
- Frame format: `KEY_W` key bits, LSB first, then a 4-bit checksum, LSB first. The checksum is the XOR of all 4-bit key nibbles.
- Transfer rule: a bit is accepted on an edge where `key_bit_valid && key_bit_ready`.
- FSM states: IDLE, SHIFT, CHECK, LOCKED, ERROR.
- IDLE: `key_bit_ready`=0. On `key_start`: go to SHIFT, clear the shift register and `bit_count`.
- SHIFT: `key_bit_ready`=1.
  - Each accepted bit is stored at index `bit_count` and increments `bit_count`.
  - When the accepted bit brings the count to `KEY_W+4`, go to CHECK.
- CHECK: one cycle, `key_bit_ready`=0. Compare the received checksum with the computed one.
  - Match: load `key_out` from the shift register, set `key_locked`=1, go to LOCKED.
  - Mismatch: set `key_error`=1, leave `key_out`=`DECOY_KEY`, go to ERROR.
- LOCKED: terminal until reset. `key_start` and bits are ignored and `key_bit_ready`=0.
- ERROR: `key_bit_ready`=0. `key_start` clears `key_error`, clears the count and goes to SHIFT.
- `key_start` in SHIFT aborts the frame: count and shift register clear, the state stays SHIFT, and no bit is accepted that cycle even if valid.
- `key_start` in CHECK is ignored.
- `key_start` and `key_bit_valid` high together in IDLE: the start is taken and the bit is not accepted (ready is low).
- Partial key bits are never visible on `key_out`. `key_out` changes only in the CHECK→LOCKED transition and on reset.

## Timing
- Reset values (asynchronous):
  - state IDLE
  - `key_out`=`DECOY_KEY`
  - `key_locked`=0, `key_error`=0
  - `key_bit_ready`=0, `bit_count`=0
- All outputs are registered. `key_bit_ready` is decoded from registered state only, with no combinational path from inputs.
- `key_start` sampled at edge E: `key_bit_ready`=1 from E (the first bit can transfer at E+1).
- Final checksum bit accepted at edge N:
  - CHECK is the state during the cycle after N.
  - `key_out` and `key_locked` (or `key_error`) update at edge N+1.
- Minimum frame time from `key_start` to lock: `KEY_W`+6 edges with `key_bit_valid` held high.
- Gaps in `key_bit_valid` stall the frame indefinitely with no timeout.
- `rst_n` asserted mid-frame or in LOCKED returns everything to reset values immediately. The next frame needs a new `key_start` after deassertion.

## Test plan
- Good load: start, then key 0x1234 (bits LSB first) and checksum 0x4 with valid held high. Require `key_out`=0x1234 and `key_locked`=1 at edge 22 after start, `key_error`=0, and `key_out`=0x0000 before that edge.
- Bad checksum: key 0x1234 with checksum 0x5. Require `key_error`=1, `key_locked`=0, `key_out`=0x0000. Then a new start with a correct frame for 0xA5C3 (checksum 0x0) gives `key_out`=0xA5C3 and `key_error`=0.
- Abort: after 7 bits of 0xFFFF, pulse `key_start` with valid high. Require `bit_count`=0 and the pulse-cycle bit not counted. Then a full frame for 0x00F0 (checksum 0xF) locks with `key_out`=0x00F0.
- Backpressure/gaps: frame 0x1234 with valid toggled 1-0-1-0. Require lock with 0x1234, `bit_count` advancing only on valid cycles, and no bit lost.
- Lock persistence: after locking 0x1234, send start plus a frame for 0xFFFF. Require `key_out` to stay 0x1234 and `key_bit_ready`=0 throughout.
- Reset mid-frame and after lock: assert `rst_n`=0 asynchronously (between edges). Require outputs to return to reset values before the next edge, `key_out`=0x0000, `key_locked`=0.
